// File: rtl/beamformer_pkg.sv
// beamformer_pkg
// Shared definitions for the delay-and-sum beamformer:
//   - default parameter values
//   - configuration address map
//   - slot encoding of the word-select line
//   - sum-width and saturation helpers
package beamformer_pkg;

    localparam int DEF_N_LINES     = 2;
    localparam int DEF_SAMPLE_BITS = 8;
    localparam int DEF_SLOT_BITS   = 16;
    localparam int DEF_DEPTH       = 8;
    localparam int DEF_OUT_BITS    = 8;

    // Channel c lives at CFG_DELAY_BASE + c; the shift register sits right after
    // the last channel, so its address depends on the channel count.
    localparam int CFG_DELAY_BASE  = 0;
    localparam int CFG_SHIFT       = 2 * DEF_N_LINES;

    typedef enum logic {
        SLOT_LEFT  = 1'b0,
        SLOT_RIGHT = 1'b1
    } slot_e;

    // Shift-register address for an arbitrary channel count.
    function automatic int cfg_shift(input int n_ch);
        return CFG_DELAY_BASE + n_ch;
    endfunction

    // Width that holds the sum of n_ch signed samples without overflow.
    function automatic int sum_width(input int sample_bits, input int n_ch);
        return sample_bits + $clog2(n_ch);
    endfunction

    // Clamp a signed value into the range of a signed out_bits-wide word.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                    input int                 out_bits);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (out_bits - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (out_bits - 1));
        if (value > max_v) begin
            return max_v;
        end else if (value < min_v) begin
            return min_v;
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/bf_i2s_rx_lane.sv
// bf_i2s_rx_lane
// Deserialises one stereo I2S data line. The parent supplies the current slot
// (ws) and slot bit position (p); bits at p = 1..SAMPLE_BITS are shifted in
// MSB-first into the left or right sample register.
// Ports:
//   clk, rst_n   bit clock, asynchronous active-low reset
//   sdi          serial data of this line
//   ws, p        current slot and bit position within the slot
//   left_r       captured left-slot sample
//   right_r      captured right-slot sample
module bf_i2s_rx_lane
    import beamformer_pkg::*;
#(
    parameter int SAMPLE_BITS = DEF_SAMPLE_BITS,
    parameter int P_W         = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sdi,
    input  logic                   ws,
    input  logic [P_W-1:0]         p,
    output logic [SAMPLE_BITS-1:0] left_r,
    output logic [SAMPLE_BITS-1:0] right_r
);

    localparam logic [P_W-1:0] P_FIRST = P_W'(1);
    localparam logic [P_W-1:0] P_LAST  = P_W'(SAMPLE_BITS);

    logic in_window_s;

    // Position 0 carries the previous word's tail in I2S, so capture starts at 1.
    always_comb begin
        in_window_s = (p >= P_FIRST) && (p <= P_LAST);
    end

    // Shift the line's bit into the sample register of the active slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left_r  <= {SAMPLE_BITS{1'b0}};
            right_r <= {SAMPLE_BITS{1'b0}};
        end else if (in_window_s) begin
            if (ws == SLOT_LEFT) begin
                left_r  <= {left_r[SAMPLE_BITS-2:0], sdi};
            end else begin
                right_r <= {right_r[SAMPLE_BITS-2:0], sdi};
            end
        end
    end

endmodule

// File: rtl/delay_sum_beamformer.sv
// delay_sum_beamformer
// Delay-and-sum beamformer with I2S input and I2S-framed mono output. The block
// is the I2S master: clk is the bit clock and ws_out is generated here.
// Each input channel feeds a DEPTH-entry delay line; the selected taps of the
// enabled channels are summed, arithmetically shifted right and saturated.
// Ports:
//   clk, rst_n     bit clock, asynchronous active-low reset
//   sdi            one serial data bit per stereo input line
//   ws_out         word select, 0 = left slot, 1 = right slot
//   sdo            beamformed serial data, same word in both slots
//   frame_strobe   one-cycle pulse after a sample set is committed
//   cfg_we/addr/wdata  config writes: per-channel {en, delay}, then shift
module delay_sum_beamformer
    import beamformer_pkg::*;
#(
    parameter int N_LINES     = DEF_N_LINES,
    parameter int SAMPLE_BITS = DEF_SAMPLE_BITS,
    parameter int SLOT_BITS   = DEF_SLOT_BITS,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int OUT_BITS    = DEF_OUT_BITS
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_LINES-1:0]             sdi,
    output logic                           ws_out,
    output logic                           sdo,
    output logic                           frame_strobe,
    input  logic                           cfg_we,
    input  logic [$clog2(2*N_LINES+1)-1:0] cfg_addr,
    input  logic [$clog2(DEPTH):0]         cfg_wdata
);

    localparam int N_CH   = 2 * N_LINES;
    localparam int SUM_W  = sum_width(SAMPLE_BITS, N_CH);
    localparam int CNT_W  = $clog2(2 * SLOT_BITS);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CFG_W  = PTR_W + 1;
    localparam int ADDR_W = $clog2(N_CH + 1);

    localparam logic [CNT_W-1:0]  CNT_ZERO    = CNT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(2 * SLOT_BITS - 1);
    localparam logic [CNT_W-1:0]  SLOT_START  = CNT_W'(SLOT_BITS);
    localparam logic [CNT_W-1:0]  OUT_P_SHIFT = CNT_W'(2);
    localparam logic [CNT_W-1:0]  OUT_P_LAST  = CNT_W'(OUT_BITS);
    localparam logic [PTR_W-1:0]  PTR_ONE     = PTR_W'(1);
    localparam logic [ADDR_W-1:0] SHIFT_ADDR  = ADDR_W'(cfg_shift(N_CH));
    localparam logic [CFG_W-1:0]  SHIFT_RST   = CFG_W'($clog2(N_CH));

    // Frame timing
    logic [CNT_W-1:0] bit_cnt_r;
    logic [CNT_W-1:0] bit_cnt_nxt_s;
    logic             ws_s;
    logic             ws_nxt_s;
    logic [CNT_W-1:0] p_s;
    logic [CNT_W-1:0] p_nxt_s;
    logic             ws_out_r;
    logic             frame_strobe_r;

    // Capture and delay lines
    logic [SAMPLE_BITS-1:0] lane_left_s  [N_LINES];
    logic [SAMPLE_BITS-1:0] lane_right_s [N_LINES];
    logic [SAMPLE_BITS-1:0] ch_sample_s  [N_CH];
    logic [SAMPLE_BITS-1:0] mem_r        [N_CH][DEPTH];
    logic [PTR_W-1:0]       wr_ptr_r;

    // Configuration
    logic [PTR_W-1:0] dly_r [N_CH];
    logic             en_r  [N_CH];
    logic [CFG_W-1:0] shift_r;

    // Datapath
    logic [PTR_W-1:0]        last_ptr_s;
    logic [PTR_W-1:0]        tap_idx_s [N_CH];
    logic [SAMPLE_BITS-1:0]  tap_s     [N_CH];
    logic signed [SUM_W-1:0] sum_s;
    logic signed [SUM_W-1:0] shifted_s;
    logic [OUT_BITS-1:0]     result_s;
    logic [OUT_BITS-1:0]     result_r;
    logic [OUT_BITS-1:0]     shreg_r;
    logic                    sdo_r;

    assign ws_out       = ws_out_r;
    assign sdo          = sdo_r;
    assign frame_strobe = frame_strobe_r;

    // Slot and bit position for the current cycle and for the one that follows.
    always_comb begin
        bit_cnt_nxt_s = (bit_cnt_r == CNT_LAST) ? CNT_ZERO : bit_cnt_r + CNT_ONE;
        ws_s          = (bit_cnt_r >= SLOT_START);
        ws_nxt_s      = (bit_cnt_nxt_s >= SLOT_START);
        p_s           = ws_s ? bit_cnt_r - SLOT_START : bit_cnt_r;
        p_nxt_s       = ws_nxt_s ? bit_cnt_nxt_s - SLOT_START : bit_cnt_nxt_s;
    end

    // Bit counter, word select and commit strobe; ws_out tracks the counter it pairs with.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_r      <= CNT_ZERO;
            ws_out_r       <= 1'b0;
            frame_strobe_r <= 1'b0;
        end else begin
            bit_cnt_r      <= bit_cnt_nxt_s;
            ws_out_r       <= ws_nxt_s;
            frame_strobe_r <= (bit_cnt_r == CNT_LAST);
        end
    end

    // One receiver per stereo line; channel 2i is left, 2i+1 is right.
    for (genvar i = 0; i < N_LINES; i++) begin : g_lane
        bf_i2s_rx_lane #(
            .SAMPLE_BITS (SAMPLE_BITS),
            .P_W         (CNT_W)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .sdi     (sdi[i]),
            .ws      (ws_s),
            .p       (p_s),
            .left_r  (lane_left_s[i]),
            .right_r (lane_right_s[i])
        );
        assign ch_sample_s[2*i]   = lane_left_s[i];
        assign ch_sample_s[2*i+1] = lane_right_s[i];
    end

    // Commit every channel's sample into its delay line at the end of the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            for (int c = 0; c < N_CH; c++) begin
                for (int d = 0; d < DEPTH; d++) begin
                    mem_r[c][d] <= {SAMPLE_BITS{1'b0}};
                end
            end
        end else if (bit_cnt_r == CNT_LAST) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
            for (int c = 0; c < N_CH; c++) begin
                mem_r[c][wr_ptr_r] <= ch_sample_s[c];
            end
        end
    end

    // Configuration writes; addresses beyond the shift register are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < N_CH; c++) begin
                dly_r[c] <= {PTR_W{1'b0}};
                en_r[c]  <= 1'b1;
            end
            shift_r <= SHIFT_RST;
        end else if (cfg_we) begin
            for (int c = 0; c < N_CH; c++) begin
                if (cfg_addr == ADDR_W'(CFG_DELAY_BASE + c)) begin
                    dly_r[c] <= cfg_wdata[PTR_W-1:0];
                    en_r[c]  <= cfg_wdata[CFG_W-1];
                end
            end
            if (cfg_addr == SHIFT_ADDR) begin
                shift_r <= cfg_wdata;
            end
        end
    end

    // Tap selection: wr_ptr already points past the newest entry, and the
    // pointer arithmetic wraps modulo DEPTH because DEPTH is a power of two.
    always_comb begin
        last_ptr_s = wr_ptr_r - PTR_ONE;
        for (int c = 0; c < N_CH; c++) begin
            tap_idx_s[c] = last_ptr_s - dly_r[c];
            tap_s[c]     = mem_r[c][tap_idx_s[c]];
        end
    end

    // Sign-extended sum of enabled taps, scaled and saturated to the output width.
    always_comb begin
        sum_s = {SUM_W{1'b0}};
        for (int c = 0; c < N_CH; c++) begin
            if (en_r[c]) begin
                sum_s = sum_s + {{(SUM_W-SAMPLE_BITS){tap_s[c][SAMPLE_BITS-1]}}, tap_s[c]};
            end else begin
                sum_s = sum_s;
            end
        end
        shifted_s = sum_s >>> shift_r;
        result_s  = OUT_BITS'(saturate(64'(shifted_s), OUT_BITS));
    end

    // Output serialiser: latch at frame start, reload at right-slot start, MSB first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r <= {OUT_BITS{1'b0}};
            shreg_r  <= {OUT_BITS{1'b0}};
            sdo_r    <= 1'b0;
        end else if (bit_cnt_r == CNT_ZERO) begin
            result_r <= result_s;
            shreg_r  <= {result_s[OUT_BITS-2:0], 1'b0};
            sdo_r    <= result_s[OUT_BITS-1];
        end else if (bit_cnt_r == SLOT_START) begin
            shreg_r  <= {result_r[OUT_BITS-2:0], 1'b0};
            sdo_r    <= result_r[OUT_BITS-1];
        end else if ((p_nxt_s >= OUT_P_SHIFT) && (p_nxt_s <= OUT_P_LAST)) begin
            shreg_r  <= {shreg_r[OUT_BITS-2:0], 1'b0};
            sdo_r    <= shreg_r[OUT_BITS-1];
        end else begin
            sdo_r    <= 1'b0;
        end
    end

endmodule

// File: doc/delay_sum_beamformer.md
Name: delay_sum_beamformer

Overview:
- Parametrised delay-and-sum beamformer.
- Deserialises N_LINES stereo I2S data lines into 2*N_LINES signed PCM channels and pushes each channel into its own DEPTH-entry sample delay line.
- Sums the per-channel delayed taps, with per-channel enable and a programmable arithmetic right shift, then saturates the result.
- Serialises the result MSB-first as an I2S-framed mono stream, identical in both slots. The block is the master: it generates ws itself, and clk is the bit clock.

Parameters:
- N_LINES, 2, number of stereo I2S input lines; channel count N_CH = 2*N_LINES, channel 2i = line i left slot, 2i+1 = line i right slot.
- SAMPLE_BITS, 8, input sample width, two's complement; SAMPLE_BITS <= SLOT_BITS-2.
- SLOT_BITS, 16, clk cycles per half-frame (ws level).
- DEPTH, 8, delay-line entries per channel; power of two, >= 2.
- OUT_BITS, 8, output sample width; OUT_BITS <= SLOT_BITS-1.

Ports:
- clk  in  1  bit clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- sdi  in  N_LINES  I2S serial data, one bit per line.
- ws_out  out  1  word select; 0 = left slot, 1 = right slot.
- sdo  out  1  beamformed serial data.
- frame_strobe  out  1  one-cycle pulse when a sample set is committed to the delay lines.
- cfg_we  in  1  config write strobe.
- cfg_addr  in  clog2(N_CH+1)  config address.
- cfg_wdata  in  clog2(DEPTH)+1  config write data.

Behaviour:
- Counter bit_cnt runs 0..2*SLOT_BITS-1 and wraps.
- ws_out = (bit_cnt >= SLOT_BITS), registered. Slot position p = bit_cnt mod SLOT_BITS.
- Capture: at p in 1..SAMPLE_BITS, shift sdi[i] MSB-first into the left (ws=0) or right (ws=1) capture register of line i. Other positions are ignored.
- Commit: on the edge where bit_cnt=2*SLOT_BITS-1:
  - every channel's sample is written to its delay memory at wr_ptr;
  - wr_ptr increments mod DEPTH;
  - frame_strobe is high for the following cycle.
- Tap: channel c reads index (last_written - delay[c]) mod DEPTH. delay=0 selects the sample just committed.
- Sum:
  - signed, width SAMPLE_BITS+clog2(N_CH), no overflow possible;
  - disabled channels contribute 0;
  - result = sum >>> shift (arithmetic), then saturate to [-2^(OUT_BITS-1), 2^(OUT_BITS-1)-1].
- Output:
  - on the edge ending bit_cnt=0, result is latched into result_r and loaded into the shift register;
  - sdo carries result_r MSB-first at p=1..OUT_BITS of the left slot;
  - reload at p=0 of the right slot; the same bits are carried at p=1..OUT_BITS of the right slot;
  - sdo=0 at all other positions.
- Latency: samples captured in frame k appear on sdo in frame k+1 (delay 0).
- Config:
  - cfg_addr < N_CH: delay[c] = cfg_wdata[clog2(DEPTH)-1:0], en[c] = cfg_wdata[MSB];
  - cfg_addr == N_CH: shift = cfg_wdata, used as unsigned;
  - other addresses are ignored.
  - Writes take effect at the next clock edge; a write mid-frame affects the next result latch only.
  - A shift >= sum width yields 0 or -1.
- Reset (async assert, sync-released by the caller):
  - bit_cnt=0, wr_ptr=0, ws_out=0, sdo=0, frame_strobe=0, result_r=0;
  - all delay memories and capture registers = 0;
  - delay[]=0, en[]=1, shift=clog2(N_CH).
  - Reset mid-frame aborts the frame immediately; the first frame after release outputs 0.

Decomposition:
- Package beamformer_pkg holds:
  - default parameter values;
  - config address map constants (CFG_DELAY_BASE=0, CFG_SHIFT=N_CH);
  - the sum-width function;
  - the saturate function.
- Sub-module bf_i2s_rx_lane, instantiated once per line: takes ws/p from the parent and outputs left/right SAMPLE_BITS registers.

Test Plan:
- Scaling: default config (shift 2), N_LINES=2, all channels send 0x40 → following frame sdo = 0x40 in both slots; frame_strobe pulses once per 32 clk.
- Positive saturation: shift=0, all channels 0x7F → sdo 0x7F. Negative saturation: all channels 0x80 → sdo 0x80.
- Delay: shift=0, delay[0]=3, en=1 only on ch0; send 0x55 on ch0 in frame 0 (zeros after) → sdo 0x00 in frames 1-3, 0x55 in frame 4, 0x00 in frame 5.
- Wrap-around: delay[1]=7, impulse 0x33 on ch1 in frame 5 → appears in frame 13 across the wr_ptr wrap; delay values 0..7 swept.
- Enable/reconfig: disable ch2, all channels 0x20, shift 0 → 0x60; write shift=1 mid-frame → next frame 0x30.
- Reset: rst_n low at bit_cnt=9 → ws_out, sdo and frame_strobe are 0 within the same cycle (async). After release, the first frame outputs 0x00 and the config registers are back at their reset values.
